// File: rtl/boot_frame_loader_if.sv
// Bus bundle between the boot frame loader and its neighbours.
// It carries two groups of signals:
// - the read side of the receive FIFO: pop request, registered data and the empty flag;
// - the instruction-memory write port: strobe, word address and data.
// Modports:
//   master - the loader: drives fifo_rd_en and the imem_* signals
//   slave  - the FIFO/imem side: drives fifo_rd_data and fifo_empty
interface boot_frame_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  fifo_rd_en;
    logic [7:0]            fifo_rd_data;
    logic                  fifo_empty;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/boot_frame_loader.sv
// Boot frame loader, in the core clock domain.
// It pops bytes from the receive FIFO and hunts for the sync byte. It then parses a frame:
//   SYNC, LEN_LO, LEN_HI, 4*LEN data bytes, CSUM.
// LEN is a count of 32-bit words. Payload bytes are packed little-endian into words and
// written to instruction memory starting at BASE_ADDR. The CPU is held in reset until a
// frame has loaded cleanly.
//
// Build option: define BOOT_CHECKSUM_EN to compare the CSUM byte against the XOR of
// LEN_LO, LEN_HI and all data bytes. Without it, the CSUM byte is popped and dropped.
//
// Ports:
//   clk, rst      core clock; synchronous active-high reset
//   bus (master)  FIFO read port and imem write port (see boot_frame_loader_if)
//   load_busy     a frame is in progress (sync seen, not yet finished)
//   load_done     sticky: the frame loaded OK
//   load_err      sticky: the frame was rejected
//   cpu_rst_hold  high until load_done
module boot_frame_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          BASE_ADDR  = 0,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    boot_frame_loader_if.master bus,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err,
    output logic                cpu_rst_hold
);
    typedef enum logic [2:0] {
        S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    // A 16-bit LEN can only exceed the memory when the memory is smaller than 2**16 words.
    localparam bit          LEN_CAP = (ADDR_WIDTH < 16);
    localparam logic [16:0] MAX_LEN = LEN_CAP ? 17'(1 << ADDR_WIDTH) : 17'h1FFFF;

    state_t                state;
    logic                  pend;       // a pop was accepted last cycle; its byte is on fifo_rd_data now
    logic [7:0]            len_lo;
    logic [15:0]           len;
    logic [15:0]           word_cnt;
    logic [1:0]            lane;
    logic [23:0]           word_buf;   // bytes 0..2 of the current word; byte 0 sits in the low bits
    logic [ADDR_WIDTH-1:0] waddr;
    logic [7:0]            rd_byte;
    logic [15:0]           len_full;
    logic                  len_over;
    logic                  last_word;
    logic                  needs_byte;
    logic                  csum_ok;

    assign rd_byte    = bus.fifo_rd_data;
    assign len_full   = {rd_byte, len_lo};
    assign len_over   = LEN_CAP && ({1'b0, len_full} > MAX_LEN);
    assign last_word  = ({1'b0, word_cnt} + 17'd1) == {1'b0, len};
    assign needs_byte = (state != S_DONE) && (state != S_ERROR);

    // Only one pop is ever outstanding, so the byte stream runs at most one byte per two clocks.
    assign bus.fifo_rd_en = !rst && !pend && !bus.fifo_empty && needs_byte;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= 8'h00;
        end else if (pend && (state == S_LEN_LO || state == S_LEN_HI || state == S_DATA)) begin
            csum <= csum ^ rd_byte;
        end
    end

    assign csum_ok = (rd_byte == csum);
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_SYNC;
            pend           <= 1'b0;
            len_lo         <= 8'h00;
            len            <= 16'h0000;
            word_cnt       <= 16'h0000;
            lane           <= 2'd0;
            word_buf       <= 24'h000000;
            waddr          <= BASE;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'h0000_0000;
            load_busy      <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            cpu_rst_hold   <= 1'b1;
        end else begin
            pend        <= bus.fifo_rd_en;
            bus.imem_we <= 1'b0;
            if (pend) begin
                case (state)
                    S_SYNC: begin
                        if (rd_byte == SYNC_BYTE) begin
                            state     <= S_LEN_LO;
                            load_busy <= 1'b1;
                        end
                    end
                    S_LEN_LO: begin
                        len_lo <= rd_byte;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        len <= len_full;
                        if (len_over) begin
                            state     <= S_ERROR;
                            load_err  <= 1'b1;
                            load_busy <= 1'b0;
                        end else if (len_full == 16'h0000) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= waddr;
                            bus.imem_wdata <= {rd_byte, word_buf};
                            waddr          <= waddr + ADDR_WIDTH'(1);
                            word_cnt       <= word_cnt + 16'd1;
                            if (last_word) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            word_buf <= {rd_byte, word_buf[23:8]};
                        end
                    end
                    S_CSUM: begin
                        load_busy <= 1'b0;
                        if (csum_ok) begin
                            state        <= S_DONE;
                            load_done    <= 1'b1;
                            cpu_rst_hold <= 1'b0;
                        end else begin
                            state    <= S_ERROR;
                            load_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
